// File: rtl/tbman_print_arb_if.sv
// APB bundle between the print arbiter (master) and the tbman slave port.
interface tbman_print_arb_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/tbman_print_arb.sv
// Shares the tbman PRINT/EXIT registers between N_REQ character streams.
// Round-robin arbitration with a per-line lock, one APB write per character,
// exit requests take priority over everything including a held lock.
module tbman_print_arb #(
   parameter int          N_REQ        = 2,
   parameter logic [15:0] PRINT_ADDR   = 16'h0000,
   parameter logic [15:0] EXIT_ADDR    = 16'h0008,
   parameter int          LOCK_TIMEOUT = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic                 exit_valid,
   input  logic [31:0]          exit_code,
   output logic                 exit_ready,
   tbman_print_arb_if.master    apbm,
   output logic                 lock_valid,
   output logic [2:0]           lock_owner,
   output logic [7:0]           slverr_count
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;

   // Timeout counter only needs to reach LOCK_TIMEOUT; 0 disables the timeout.
   localparam bit              TMO_EN   = (LOCK_TIMEOUT > 0);
   localparam int              TW       = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
   localparam logic [TW-1:0]   TMO_LAST = TW'(LOCK_TIMEOUT);

   logic [1:0]    state;
   logic [2:0]    last_grant;
   logic [TW-1:0] tmo_cnt;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [15:0]   paddr;
   logic [31:0]   pwdata;

   // Requester vectors padded to the 8-requester maximum so a 3-bit index always fits.
   logic [7:0]    valid_pad;
   logic [63:0]   data_pad;
   logic          rr_found;
   logic [2:0]    rr_idx;
   logic [2:0]    cand;
   logic          exit_go;
   logic          grant_go;
   logic [2:0]    grant_idx;
   logic [7:0]    grant_char;
   logic          tmo_inc;
   logic          tmo_hit;
   logic          unused_prdata;

   assign valid_pad     = 8'(req_valid);
   assign data_pad      = 64'(req_data);
   assign grant_char    = data_pad[{grant_idx, 3'b000} +: 8];
   assign unused_prdata = ^apbm.prdata;

   assign apbm.psel     = psel;
   assign apbm.penable  = penable;
   assign apbm.pwrite   = pwrite;
   assign apbm.paddr    = paddr;
   assign apbm.pwdata   = pwdata;
   assign exit_ready    = exit_go;

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = 3'd0;
      cand     = 3'd0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = 3'((int'(last_grant) + k) % N_REQ);
         if (!rr_found && valid_pad[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end else begin
            rr_found = rr_found;
         end
      end
   end

   // Grant decision in IDLE: exit first, then the lock owner, then round-robin.
   always_comb begin
      exit_go   = 1'b0;
      grant_go  = 1'b0;
      grant_idx = 3'd0;
      tmo_inc   = 1'b0;
      tmo_hit   = 1'b0;
      if (state == S_IDLE) begin
         if (exit_valid) begin
            exit_go = 1'b1;
         end else if (lock_valid) begin
            if (valid_pad[lock_owner]) begin
               grant_go  = 1'b1;
               grant_idx = lock_owner;
            end else begin
               tmo_inc = TMO_EN;
               tmo_hit = TMO_EN && ((tmo_cnt + TW'(1)) == TMO_LAST);
            end
         end else if (rr_found) begin
            grant_go  = 1'b1;
            grant_idx = rr_idx;
         end else begin
            grant_go = 1'b0;
         end
      end else begin
         grant_go = 1'b0;
      end
   end

   // One-hot accept towards the granted requester, only in the grant cycle.
   always_comb begin
      req_ready = {N_REQ{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = grant_go && (grant_idx == 3'(i));
      end
   end

   // APB sequencer: IDLE -> SETUP -> ACCESS (waits on pready) -> IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         psel    <= 1'b0;
         penable <= 1'b0;
         pwrite  <= 1'b0;
         paddr   <= 16'h0000;
         pwdata  <= 32'h0000_0000;
      end else begin
         case (state)
            S_IDLE: begin
               if (exit_go) begin
                  state  <= S_SETUP;
                  psel   <= 1'b1;
                  pwrite <= 1'b1;
                  paddr  <= EXIT_ADDR;
                  pwdata <= exit_code;
               end else if (grant_go) begin
                  state  <= S_SETUP;
                  psel   <= 1'b1;
                  pwrite <= 1'b1;
                  paddr  <= PRINT_ADDR;
                  pwdata <= {24'h00_0000, grant_char};
               end else begin
                  state <= S_IDLE;
               end
            end
            S_SETUP: begin
               state   <= S_ACCESS;
               penable <= 1'b1;
            end
            S_ACCESS: begin
               if (apbm.pready) begin
                  state   <= S_IDLE;
                  psel    <= 1'b0;
                  penable <= 1'b0;
                  pwrite  <= 1'b0;
               end else begin
                  state <= S_ACCESS;
               end
            end
            default: begin
               state   <= S_IDLE;
               psel    <= 1'b0;
               penable <= 1'b0;
               pwrite  <= 1'b0;
            end
         endcase
      end
   end

   // Line lock, round-robin pointer and idle-timeout bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_valid <= 1'b0;
         lock_owner <= 3'd0;
         last_grant <= 3'd0;
         tmo_cnt    <= {TW{1'b0}};
      end else begin
         if (exit_go) begin
            lock_valid <= 1'b0;
            tmo_cnt    <= {TW{1'b0}};
         end else if (grant_go) begin
            last_grant <= grant_idx;
            lock_owner <= grant_idx;
            lock_valid <= (grant_char != 8'h0A);
            tmo_cnt    <= {TW{1'b0}};
         end else if (tmo_hit) begin
            lock_valid <= 1'b0;
            tmo_cnt    <= {TW{1'b0}};
         end else if (tmo_inc) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end else if (!lock_valid) begin
            tmo_cnt <= {TW{1'b0}};
         end else begin
            tmo_cnt <= tmo_cnt;
         end
      end
   end

   // Saturating count of completed transfers that returned pslverr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slverr_count <= 8'h00;
      end else if ((state == S_ACCESS) && apbm.pready && apbm.pslverr && (slverr_count != 8'hFF)) begin
         slverr_count <= slverr_count + 8'h01;
      end else begin
         slverr_count <= slverr_count;
      end
   end

endmodule
